dpram_fifo_ctrl: RTL



---
 rtl/dpram_fifo_ctrl_pkg.sv | 10 +
 rtl/dpram_fifo_ctrl_if.sv | 11 +
 rtl/dpram_fifo_ctrl_out_buf.sv | 48 ++++
 rtl/dpram_fifo_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared widths and types for the dual-port-RAM FIFO controller.
package dpram_fifo_pkg;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DEPTH  = 64;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] ptr_t;
   typedef logic [ADDR_W+1:0] count_t;
endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Valid/ready word stream; master drives data/valid, slave drives ready.
interface dpram_fifo_ctrl_if;
   import dpram_fifo_pkg::*;

   data_t data;
   logic  valid;
   logic  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dpram_fifo_ctrl_out_buf.sv
// Two-entry in-order output buffer that absorbs the RAM's one-cycle read latency.
module fifo_out_buf
   import dpram_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push_valid,
   input  data_t      push_data,
   input  logic       pop_ready,
   output data_t      m_data,
   output logic       m_valid,
   output logic [1:0] ob_cnt
);
   data_t entry1;
   logic  pop;

   assign m_valid = (ob_cnt != 2'd0);
   assign pop     = m_valid && pop_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data <= '0;
         entry1 <= '0;
         ob_cnt <= '0;
      end else if (flush) begin
         m_data <= '0;
         entry1 <= '0;
         ob_cnt <= '0;
      end else begin
         // A return landing in the same cycle as a pop goes to whichever slot becomes the tail.
         if (pop) begin
            if (ob_cnt == 2'd2)
               m_data <= entry1;
            else if (push_valid)
               m_data <= push_data;
            if (ob_cnt == 2'd2 && push_valid)
               entry1 <= push_data;
         end else if (push_valid) begin
            if (ob_cnt == 2'd0)
               m_data <= push_data;
            else
               entry1 <= push_data;
         end
         ob_cnt <= ob_cnt + 2'(push_valid) - 2'(pop);
      end
   end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO sequencer around an external 64x8 dual-port RAM (A = write, B = read).
// Optional peak-occupancy register enabled by defining FIFO_HWM_EN.
module dpram_fifo_ctrl
   import dpram_fifo_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   flush,
   dpram_fifo_ctrl_if.slave  s,
   dpram_fifo_ctrl_if.master m,
   output count_t count,
   output ptr_t   ram_addr_a,
   output data_t  ram_data_a,
   output logic   ram_we_a,
   output ptr_t   ram_addr_b,
   output logic   ram_we_b,
   input  data_t  ram_q_b,
   output count_t hwm,
   input  logic   hwm_clr
);
   ptr_t       wr_ptr;
   ptr_t       rd_ptr;
   count_t     mem_cnt;
   logic       rd_inflight;
   logic [1:0] ob_cnt;
   logic       s_ready;
   logic       m_valid;
   logic       push;
   logic       pop;
   logic       issue;

   assign s_ready = (mem_cnt < count_t'(DEPTH));
   assign s.ready = s_ready;
   assign m.valid = m_valid;

   assign push = s.valid && s_ready && !flush;
   assign pop  = m_valid && m.ready;
   // Buffer slots already claimed (held + in flight) less the one leaving this cycle must stay below 2.
   assign issue = !flush && (mem_cnt != '0) &&
                  (({1'b0, ob_cnt} + {2'b0, rd_inflight}) < (3'd2 + {2'b0, pop}));

   assign ram_we_a   = push;
   assign ram_addr_a = wr_ptr;
   assign ram_data_a = s.data;
   assign ram_addr_b = rd_ptr;
   assign ram_we_b   = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mem_cnt     <= '0;
         rd_inflight <= 1'b0;
         count       <= '0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mem_cnt     <= '0;
         rd_inflight <= 1'b0;
         count       <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (issue)
            rd_ptr <= rd_ptr + 1'b1;
         mem_cnt     <= mem_cnt + count_t'(push) - count_t'(issue);
         rd_inflight <= issue;
         // Issue and return only move words between stages, so total occupancy tracks push/pop alone.
         count       <= count + count_t'(push) - count_t'(pop);
      end
   end

   fifo_out_buf u_out_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .push_valid (rd_inflight),
      .push_data  (ram_q_b),
      .pop_ready  (m.ready),
      .m_data     (m.data),
      .m_valid    (m_valid),
      .ob_cnt     (ob_cnt)
   );

`ifdef FIFO_HWM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hwm <= '0;
      else if (hwm_clr)
         hwm <= count;
      else if (count > hwm)
         hwm <= count;
   end
`else
   logic unused_hwm_clr;
   assign unused_hwm_clr = hwm_clr;
   assign hwm = '0;
`endif
endmodule
